// File: rtl/ldpc_ctrl_pkg.sv
// Shared definitions for the LDPC iteration sequencer: phase bus encodings,
// code-rate encodings, default pass geometry and the internal state type.
package ldpc_ctrl_pkg;

  // One-hot phase codes driven on the shared fsm bus
  localparam logic [3:0] FSM_IDLE = 4'b0000;
  localparam logic [3:0] FSM_LOAD = 4'b0001;
  localparam logic [3:0] FSM_VAR  = 4'b0010;
  localparam logic [3:0] FSM_CHK  = 4'b0100;
  localparam logic [3:0] FSM_OUT  = 4'b1000;

  // Code rate encodings on rate_in / rate
  localparam logic RATE_1_2 = 1'b0;
  localparam logic RATE_3_4 = 1'b1;

  // Default pass geometry
  localparam int DEF_CHK_ROWS_R0 = 18;
  localparam int DEF_CHK_ROWS_R1 = 9;
  localparam int DEF_VAR_LEN     = 256;
  localparam int DEF_IT_WID      = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHK,
    ST_VAR,
    ST_OUT
  } state_t;

  // Map the internal state onto the one-hot phase bus
  function automatic logic [3:0] fsm_code(input state_t s);
    case (s)
      ST_LOAD: fsm_code = FSM_LOAD;
      ST_CHK:  fsm_code = FSM_CHK;
      ST_VAR:  fsm_code = FSM_VAR;
      ST_OUT:  fsm_code = FSM_OUT;
      default: fsm_code = FSM_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ldpc_iter_ctrl_phase_cnt.sv
// ldpc_phase_cnt: loadable down-counter with a terminal-count flag.
// Loaded with (phase length - 1) on phase entry; tc is high on the last
// cycle of the phase. The count parks at zero rather than wrapping.
module ldpc_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Load has priority over counting; stop at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: iteration sequencer for the LDPC decoder core.
// Steps LOAD -> (CHK -> VAR) x N -> OUT and drives the shared fsm/cycle/rate
// bus. Optional macro LDPC_EARLY_STOP_EN: when defined, syndrome_ok on the
// last VAR cycle ends the frame early.
module ldpc_iter_ctrl
  import ldpc_ctrl_pkg::*;
#(
  parameter int CHK_ROWS_R0 = DEF_CHK_ROWS_R0,
  parameter int CHK_ROWS_R1 = DEF_CHK_ROWS_R1,
  parameter int VAR_LEN     = DEF_VAR_LEN,
  parameter int IT_WID      = DEF_IT_WID
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rate_in,
  input  logic [IT_WID-1:0] max_iter,
  input  logic              load_done,
  input  logic              out_done,
  input  logic              syndrome_ok,
  output logic [3:0]        fsm,
  output logic [1:0]        cycle,
  output logic              rate,
  output logic              busy,
  output logic              dec_done,
  output logic [IT_WID-1:0] iter_used,
  output logic              conv
);

  localparam int CHK_MAX = ((CHK_ROWS_R0 > CHK_ROWS_R1) ? CHK_ROWS_R0 : CHK_ROWS_R1) * 4;
  localparam int CHK_W   = (CHK_MAX > 1) ? $clog2(CHK_MAX) : 1;
  localparam int VAR_W   = (VAR_LEN > 1) ? $clog2(VAR_LEN) : 1;

  // Saturating iteration increment
  function automatic logic [IT_WID-1:0] sat_inc(input logic [IT_WID-1:0] v);
    sat_inc = (v == {IT_WID{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t            state, state_nxt;
  logic [IT_WID-1:0] max_iter_q;
  logic [IT_WID-1:0] iter_inc;
  logic [CHK_W-1:0]  chk_len_m1;
  logic              start_acc;
  logic              chk_load, chk_en, chk_tc;
  logic              var_load, var_en, var_tc;
  logic              last_var;

  // A start coinciding with the completion pulse belongs to the old frame
  assign start_acc = (state == ST_IDLE) && start && !dec_done;
  assign iter_inc  = sat_inc(iter_used);
  assign last_var  = (state == ST_VAR) && var_tc;

  // CHK length follows the rate latched for this frame
  assign chk_len_m1 = (rate == RATE_3_4) ? CHK_W'(CHK_ROWS_R1 * 4 - 1)
                                         : CHK_W'(CHK_ROWS_R0 * 4 - 1);

  assign chk_load = (state_nxt == ST_CHK) && (state != ST_CHK);
  assign chk_en   = (state == ST_CHK);
  assign var_load = (state_nxt == ST_VAR) && (state != ST_VAR);
  assign var_en   = (state == ST_VAR);

  // CHK phase: rows*4 cycles, row/cycle position implied by the count
  ldpc_phase_cnt #(.W(CHK_W)) u_chk_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (chk_load),
    .load_val (chk_len_m1),
    .en       (chk_en),
    .tc       (chk_tc)
  );

  // VAR phase: VAR_LEN cycles
  ldpc_phase_cnt #(.W(VAR_W)) u_var_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (var_load),
    .load_val (VAR_W'(VAR_LEN - 1)),
    .en       (var_en),
    .tc       (var_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_acc) state_nxt = ST_LOAD;
      ST_LOAD: if (load_done) state_nxt = ST_CHK;
      ST_CHK:  if (chk_tc)    state_nxt = ST_VAR;
      ST_VAR: begin
        if (var_tc) begin
`ifdef LDPC_EARLY_STOP_EN
          if ((iter_inc == max_iter_q) || syndrome_ok) state_nxt = ST_OUT;
          else                                          state_nxt = ST_CHK;
`else
          if (iter_inc == max_iter_q) state_nxt = ST_OUT;
          else                        state_nxt = ST_CHK;
`endif
        end
      end
      ST_OUT:  if (out_done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered phase bus, busy flag, sub-cycle and completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm      <= FSM_IDLE;
      busy     <= 1'b0;
      cycle    <= 2'd0;
      dec_done <= 1'b0;
    end else begin
      fsm      <= fsm_code(state_nxt);
      busy     <= (state_nxt != ST_IDLE);
      cycle    <= ((state == ST_CHK) && (state_nxt == ST_CHK)) ? cycle + 2'd1 : 2'd0;
      dec_done <= (state == ST_OUT) && out_done;
    end
  end

  // Frame parameters, iteration count and convergence flag
  always_ff @(posedge clk) begin
    if (reset) begin
      rate       <= RATE_1_2;
      max_iter_q <= '0;
      iter_used  <= '0;
      conv       <= 1'b0;
    end else if (start_acc) begin
      rate       <= rate_in;
      max_iter_q <= (max_iter == '0) ? IT_WID'(1) : max_iter;
      iter_used  <= '0;
      conv       <= 1'b0;
    end else if (last_var) begin
      iter_used  <= iter_inc;
      conv       <= syndrome_ok;
    end
  end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed self-checking bench for ldpc_iter_ctrl (default geometry 18/9/256).
module tb_ldpc_iter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rate_in;
  logic [5:0] max_iter;
  logic       load_done;
  logic       out_done;
  logic       syndrome_ok;
  logic [3:0] fsm;
  logic [1:0] cycle;
  logic       rate;
  logic       busy;
  logic       dec_done;
  logic [5:0] iter_used;
  logic       conv;

  int checks = 0;
  int errors = 0;

  ldpc_iter_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rate_in     (rate_in),
    .max_iter    (max_iter),
    .load_done   (load_done),
    .out_done    (out_done),
    .syndrome_ok (syndrome_ok),
    .fsm         (fsm),
    .cycle       (cycle),
    .rate        (rate),
    .busy        (busy),
    .dec_done    (dec_done),
    .iter_used   (iter_used),
    .conv        (conv)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count cycles spent in phase 'code'; bad counts wrong cycle or rate values.
  // With disturb set, start/load_done/rate_in are toggled inside the phase.
  task automatic measure(input logic [3:0] code, input logic disturb, input logic exp_rate,
                         output int len, output int bad);
    len = 0;
    bad = 0;
    while (fsm === code && len < 2000) begin
      if (code == 4'b0100) begin
        if (cycle !== 2'(len % 4)) bad++;
      end else if (cycle !== 2'd0) begin
        bad++;
      end
      if (rate !== exp_rate) bad++;
      if (disturb) begin
        start     = len[0];
        load_done = ~len[0];
        rate_in   = len[1];
      end
      len++;
      tick();
    end
    start     = 1'b0;
    load_done = 1'b0;
  endtask

  initial begin
    int len;
    int bad;
    int iters;
    int exp_it;

    reset = 1'b1; start = 1'b0; rate_in = 1'b0; max_iter = 6'd0;
    load_done = 1'b0; out_done = 1'b0; syndrome_ok = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_fsm", fsm, 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_cycle", cycle, 0);
    check("rst_rate", rate, 0);
    check("rst_dec_done", dec_done, 0);
    check("rst_iter", iter_used, 0);
    check("rst_conv", conv, 0);
    reset = 1'b0;
    tick();

    // Frame A: rate 0, max_iter 2, no convergence
    start = 1'b1; rate_in = 1'b0; max_iter = 6'd2;
    tick();
    start = 1'b0;
    check("a_load", fsm, 4'b0001);
    check("a_busy", busy, 1);
    tick(); tick();
    check("a_load_wait", fsm, 4'b0001);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("a_chk1_entry", fsm, 4'b0100);
    measure(4'b0100, 1'b0, 1'b0, len, bad);
    check("a_chk1_len", len, 72);
    check("a_chk1_bad", bad, 0);
    check("a_var1_entry", fsm, 4'b0010);
    measure(4'b0010, 1'b0, 1'b0, len, bad);
    check("a_var1_len", len, 256);
    check("a_var1_bad", bad, 0);
    check("a_iter1", iter_used, 1);
    check("a_chk2_entry", fsm, 4'b0100);
    measure(4'b0100, 1'b0, 1'b0, len, bad);
    check("a_chk2_len", len, 72);
    measure(4'b0010, 1'b0, 1'b0, len, bad);
    check("a_var2_len", len, 256);
    check("a_out", fsm, 4'b1000);
    check("a_iter", iter_used, 2);
    check("a_conv", conv, 0);
    tick(); tick();
    check("a_out_wait", fsm, 4'b1000);
    check("a_no_done_early", dec_done, 0);
    out_done = 1'b1;
    tick();
    check("a_done_pulse", dec_done, 1);
    check("a_idle", fsm, 4'b0000);
    check("a_idle_busy", busy, 0);
    tick();
    out_done = 1'b0;
    check("a_done_one_cycle", dec_done, 0);
    check("a_iter_hold", iter_used, 2);

    // Frame B: rate 1, max_iter 0 (one iteration), disturbances during CHK
    start = 1'b1; rate_in = 1'b1; max_iter = 6'd0;
    tick();
    start = 1'b0; rate_in = 1'b0;
    check("b_load", fsm, 4'b0001);
    check("b_rate", rate, 1);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    measure(4'b0100, 1'b1, 1'b1, len, bad);
    check("b_chk_len", len, 36);
    check("b_chk_bad", bad, 0);
    check("b_var_entry", fsm, 4'b0010);
    measure(4'b0010, 1'b0, 1'b1, len, bad);
    check("b_var_len", len, 256);
    check("b_var_bad", bad, 0);
    check("b_out", fsm, 4'b1000);
    check("b_iter", iter_used, 1);
    check("b_rate_out", rate, 1);

    // Back-to-back: start held from the dec_done cycle onwards
    out_done = 1'b1;
    tick();
    out_done = 1'b0;
    check("bb_done", dec_done, 1);
    start = 1'b1; rate_in = 1'b0; max_iter = 6'd10;
    tick();
    check("bb_ignored", fsm, 4'b0000);
    check("bb_iter_kept", iter_used, 1);
    tick();
    start = 1'b0;
    check("bb_load", fsm, 4'b0001);
    check("bb_iter_clr", iter_used, 0);
    check("bb_rate", rate, 0);

    // Frame C: max_iter 10, syndrome_ok from the end of iteration 3 onwards
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    iters = 0;
    while (fsm === 4'b0100 && iters < 12) begin
      if (iters >= 2) syndrome_ok = 1'b1;
      measure(4'b0100, 1'b0, 1'b0, len, bad);
      measure(4'b0010, 1'b0, 1'b0, len, bad);
      iters++;
    end
    syndrome_ok = 1'b0;
`ifdef LDPC_EARLY_STOP_EN
    exp_it = 3;
`else
    exp_it = 10;
`endif
    check("c_out", fsm, 4'b1000);
    check("c_iters", iters, exp_it);
    check("c_iter_used", iter_used, exp_it);
    check("c_conv", conv, 1);
    out_done = 1'b1;
    tick();
    out_done = 1'b0;
    check("c_done", dec_done, 1);
    tick();
    check("c_conv_hold", conv, 1);
    check("c_iter_hold", iter_used, exp_it);

    // Frame D: reset in the middle of the second CHK pass
    start = 1'b1; rate_in = 1'b1; max_iter = 6'd3;
    tick();
    start = 1'b0;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    measure(4'b0100, 1'b0, 1'b1, len, bad);
    measure(4'b0010, 1'b0, 1'b1, len, bad);
    check("d_iter1", iter_used, 1);
    repeat (10) tick();
    check("d_mid_chk", fsm, 4'b0100);
    reset = 1'b1;
    tick();
    check("d_rst_fsm", fsm, 4'b0000);
    check("d_rst_busy", busy, 0);
    check("d_rst_done", dec_done, 0);
    check("d_rst_iter", iter_used, 0);
    check("d_rst_cycle", cycle, 0);
    reset = 1'b0;
    tick();
    check("d_post_done", dec_done, 0);
    check("d_post_fsm", fsm, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
